// File: rtl/multi_block_window_gen_pkg.sv
// multi_block_window_gen_pkg: shared window geometry (edge, element offset, window count) for the window generator and mean stage
package multi_block_window_gen_pkg;
  localparam int MBW_W = 9;
  function automatic int mbw_edge(input int scale, input int mask);
    return scale * mask;
  endfunction
  function automatic int mbw_elem_off(input int r, input int c, input int w, input int dw);
    return (r * w + c) * dw;
  endfunction
  function automatic int mbw_win_count(input int h, input int wi, input int w);
    return (h - w + 1) * (wi - w + 1);
  endfunction
endpackage

// File: rtl/multi_block_window_gen_line_buffer.sv
// mbw_line_buffer: one image line of storage, read-before-write at a shared address
module mbw_line_buffer #(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_DEPTH = 640
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(P_DEPTH)-1:0] i_addr,
  input  logic [P_DATA_WIDTH-1:0]    i_wdata,
  output logic [P_DATA_WIDTH-1:0]    o_rdata
);
  logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];
  assign o_rdata = r_mem[i_addr];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
endmodule

// File: rtl/multi_block_window_gen.sv
// multi_block_window_gen: raster stream to flattened WxW window, 2-cycle latency; MBW_FRAME_END_EN adds o_eof on the last window of a frame
module multi_block_window_gen
  import multi_block_window_gen_pkg::*;
#(
  parameter int P_DATA_WIDTH = 20,
  parameter int P_SCALE_SIZE = 3,
  parameter int P_MASK_SIZE = 3,
  parameter int P_IMG_WIDTH = 640,
  parameter int P_IMG_HEIGHT = 512
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic                    i_sof,
  input  logic [P_DATA_WIDTH-1:0] i_data,
  output logic                    o_valid,
  output logic [P_DATA_WIDTH*P_SCALE_SIZE*P_SCALE_SIZE*P_MASK_SIZE*P_MASK_SIZE-1:0] o_data
`ifdef MBW_FRAME_END_EN
  ,
  output logic                    o_eof
`endif
);
  localparam int W = mbw_edge(P_SCALE_SIZE, P_MASK_SIZE);
  localparam int DW = P_DATA_WIDTH;
  localparam int CW = $clog2(P_IMG_WIDTH);
  localparam int RW = $clog2(P_IMG_HEIGHT);
  localparam logic [CW-1:0] C_LAST = CW'(P_IMG_WIDTH - 1);
  localparam logic [CW-1:0] C_MIN = CW'(W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(P_IMG_HEIGHT - 1);
  localparam logic [RW-1:0] R_MIN = RW'(W - 1);
  logic [CW-1:0] r_col, r_c1, w_col;
  logic [RW-1:0] r_row, r_r1, w_row;
  logic [DW-1:0] r_pix;
  logic r_v1, r_v2, r_ok2;
  logic [DW*W*W-1:0] r_win, w_nxt;
  logic [DW-1:0] w_tap [W];
  assign w_col = i_sof ? '0 : r_col;
  assign w_row = i_sof ? '0 : r_row;
  assign w_tap[0] = r_pix;
  for (genvar k = 0; k < W - 1; k++) begin : g_lb
    mbw_line_buffer #(.P_DATA_WIDTH(DW), .P_DEPTH(P_IMG_WIDTH)) u_lb (
      .i_clk(i_clk),
      .i_we(r_v1),
      .i_addr(r_c1),
      .i_wdata(w_tap[k]),
      .o_rdata(w_tap[k+1])
    );
  end
  for (genvar r = 0; r < W; r++) begin : g_row
    assign w_nxt[mbw_elem_off(r, 0, W, DW) +: DW*(W-1)] = r_win[mbw_elem_off(r, 1, W, DW) +: DW*(W-1)];
    assign w_nxt[mbw_elem_off(r, W-1, W, DW) +: DW] = w_tap[W-1-r];
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_c1 <= '0;
      r_r1 <= '0;
      r_pix <= '0;
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_ok2 <= 1'b0;
      r_win <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r_pix <= i_data;
        r_c1 <= w_col;
        r_r1 <= w_row;
        r_col <= (w_col == C_LAST) ? '0 : w_col + 1'b1;
        r_row <= (w_col != C_LAST) ? w_row : (w_row == R_LAST) ? '0 : w_row + 1'b1;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_ok2 <= (r_r1 >= R_MIN) && (r_c1 >= C_MIN);
        r_win <= w_nxt;
      end
      o_valid <= r_v2 && r_ok2;
      o_data <= (r_v2 && r_ok2) ? r_win : '0;
    end
`ifdef MBW_FRAME_END_EN
  logic r_end2;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_end2 <= 1'b0;
      o_eof <= 1'b0;
    end else begin
      if (r_v1) r_end2 <= (r_r1 == R_LAST) && (r_c1 == C_LAST);
      o_eof <= r_v2 && r_ok2 && r_end2;
    end
`endif
endmodule

// File: tb/tb_multi_block_window_gen.sv
// tb_multi_block_window_gen: scoreboard bench for the window generator on a 12x10 image with 9x9 windows
module tb_multi_block_window_gen;
  localparam int DW = 20;
  localparam int W = 9;
  localparam int IW = 12;
  localparam int IH = 10;
  localparam int NB = DW * W * W;
  typedef struct {
    logic [NB-1:0] d;
    int e;
    bit eof;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, i_valid, i_sof, o_valid;
  logic [DW-1:0] i_data;
  logic [NB-1:0] o_data;
`ifdef MBW_FRAME_END_EN
  logic o_eof;
`endif
  exp_t q[$];
  int img [IH][IW];
  int n_chk = 0, n_fail = 0, n_edge = 0, n_win = 0;
  int mrow = 0, mcol = 0;
  int f00, f88, l00, l88;
  multi_block_window_gen #(
    .P_DATA_WIDTH(DW), .P_SCALE_SIZE(3), .P_MASK_SIZE(3), .P_IMG_WIDTH(IW), .P_IMG_HEIGHT(IH)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_valid(i_valid),
    .i_sof(i_sof),
    .i_data(i_data),
    .o_valid(o_valid),
    .o_data(o_data)
`ifdef MBW_FRAME_END_EN
    ,
    .o_eof(o_eof)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) n_edge <= n_edge + 1;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask
  task automatic px(input bit sof, input int off);
    int r, c;
    exp_t x;
    r = sof ? 0 : mrow;
    c = sof ? 0 : mcol;
    i_valid = 1'b1;
    i_sof = sof;
    i_data = DW'(off + r * 16 + c);
    img[r][c] = off + r * 16 + c;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_sof = 1'b0;
    if (r >= W - 1 && c >= W - 1) begin
      for (int a = 0; a < W; a++)
        for (int b = 0; b < W; b++)
          x.d[(a * W + b) * DW +: DW] = DW'(img[r - W + 1 + a][c - W + 1 + b]);
      x.e = n_edge;
      x.eof = (r == IH - 1) && (c == IW - 1);
      q.push_back(x);
    end
    mcol = (c == IW - 1) ? 0 : c + 1;
    mrow = (c != IW - 1) ? r : (r == IH - 1) ? 0 : r + 1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input bit sof_first, input int off, input bit rnd);
    for (int i = 0; i < IW * IH; i++) begin
      if (rnd && $urandom_range(0, 1) == 1) idle(1);
      px(sof_first && i == 0, off);
    end
  endtask
  task automatic scn(input string nm, input int cnt, input int e00, input int e88, input int z00, input int z88);
    idle(6);
    chk({nm, "_count"}, n_win, cnt);
    chk({nm, "_drained"}, q.size(), 0);
    chk({nm, "_first00"}, f00, e00);
    chk({nm, "_first88"}, f88, e88);
    chk({nm, "_last00"}, l00, z00);
    chk({nm, "_last88"}, l88, z88);
    n_win = 0;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (o_valid) begin
        n_win++;
        if (n_win == 1) begin
          f00 = int'(o_data[DW-1:0]);
          f88 = int'(o_data[(W * W - 1) * DW +: DW]);
        end
        l00 = int'(o_data[DW-1:0]);
        l88 = int'(o_data[(W * W - 1) * DW +: DW]);
        if (q.size() == 0) chk("unexpected_window", 1, 0);
        else begin
          exp_t x;
          x = q.pop_front();
          n_chk++;
          if (o_data !== x.d) begin
            n_fail++;
            for (int i = 0; i < W * W; i++)
              if (o_data[i * DW +: DW] !== x.d[i * DW +: DW]) begin
                $display("FAIL win_data elem %0d got %0h exp %0h", i, o_data[i * DW +: DW], x.d[i * DW +: DW]);
                break;
              end
          end
          chk("win_latency", n_edge, x.e + 2);
`ifdef MBW_FRAME_END_EN
          chk("eof_on_window", o_eof, x.eof);
`endif
        end
      end else begin
        chk("idle_data_zero", o_data == '0, 1);
`ifdef MBW_FRAME_END_EN
        chk("idle_eof_low", o_eof, 0);
`endif
      end
    end
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0;
    i_sof = 1'b0;
    i_data = '0;
    idle(3);
    chk("reset_valid", o_valid, 0);
    chk("reset_data_zero", o_data == '0, 1);
    rst_n = 1'b1;
    idle(2);
    frame(1, 0, 0);
    scn("continuous", 8, 0, 136, 19, 155);
    frame(1, 0, 1);
    scn("gapped", 8, 0, 136, 19, 155);
    frame(1, 0, 0);
    frame(1, 'h800, 0);
    scn("two_frames", 16, 0, 136, 'h800 + 19, 'h800 + 155);
    for (int i = 0; i < 5 * IW + 3; i++) px(i == 0, 'h400);
    frame(1, 0, 0);
    scn("mid_sof", 8, 0, 136, 19, 155);
    for (int i = 0; i < 9 * IW + 11; i++) px(i == 0, 0);
    chk("pre_reset_valid", o_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", o_valid, 0);
    chk("async_reset_data_zero", o_data == '0, 1);
    q.delete();
    mrow = 0;
    mcol = 0;
    idle(2);
    rst_n = 1'b1;
    n_win = 0;
    frame(0, 0, 0);
    scn("after_reset", 8, 0, 136, 19, 155);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_block_window_gen.md
# multi_block_window_gen

Streaming window generator that converts a raster pixel stream into the flattened square window consumed by the multi-block mean stage. It buffers the last P_SCALE_SIZE*P_MASK_SIZE−1 image lines and emits one full window per accepted pixel once that window lies entirely inside the frame. It sits between the infrared pixel source and the block-mean/contrast pipeline. Its output bus matches the window bus layout of the downstream stage bit for bit.

## Interface
- P_DATA_WIDTH, 20, pixel width in bits.
- P_SCALE_SIZE, 3, block edge length in pixels.
- P_MASK_SIZE, 3, blocks per window edge; window edge W = P_SCALE_SIZE*P_MASK_SIZE (localparam).
- P_IMG_WIDTH, 640, pixels per line. Must be ≥ W.
- P_IMG_HEIGHT, 512, lines per frame. Must be ≥ W.
- i_clk  input  1  single clock for the whole block.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_valid  input  1  pixel qualifier; no backpressure, so every high cycle consumes one pixel.
- i_sof  input  1  start of frame. Meaningful only with i_valid; marks that pixel as (row 0, col 0).
- i_data  input  P_DATA_WIDTH  pixel in raster order.
- o_valid  output  1  window qualifier.
- o_data  output  P_DATA_WIDTH*W*W  window. Element (r,c) sits at bits [(r*W+c)*P_DATA_WIDTH +: P_DATA_WIDTH]. r=0 is the oldest (top) line and c=0 is the leftmost column.

## Operation
- Position counters:
  - col counts 0..P_IMG_WIDTH−1 on each i_valid.
  - row increments when col wraps and counts 0..P_IMG_HEIGHT−1.
  - Both wrap to 0 after pixel (H−1, W_img−1).
  - i_valid&i_sof forces the current pixel to (0,0). Counters then continue from there, regardless of their previous state.
- Line buffers:
  - W−1 buffers, each P_IMG_WIDTH deep by P_DATA_WIDTH wide, chained.
  - On each accepted pixel, every buffer does a read-before-write at address col.
  - Buffer 0 writes the incoming pixel. Buffer k writes the read data of buffer k−1.
  - The output of buffer k is therefore the pixel (k+1) lines above.
- Window register:
  - W×W pixel array.
  - On each pipeline-valid cycle, all columns shift left by one.
  - The new column c=W−1 is loaded with rows 0..W−2 = buffer W−2..0 outputs and row W−1 = current pixel.
- Window validity: a window is emitted only when the completing pixel has row ≥ W−1 and col ≥ W−1. No border padding.
- Window count per frame is (P_IMG_HEIGHT−W+1)*(P_IMG_WIDTH−W+1), e.g. 504*632 for the defaults.
- Line buffers are never cleared:
  - Stale data from a previous frame is harmless because the validity rule masks it.
  - Line-buffer RAM is not reset; the rule keeps uninitialised contents unobservable.
- Arithmetic: pure data movement; no pixel is modified.
- o_data is driven to 0 whenever o_valid is low.

## Timing
- The pipeline has three registered stages: input/counter capture, then window shift, then output register.
- A pixel sampled at edge N produces o_valid high in the cycle after edge N+2. Fixed latency is 2 cycles.
- Each stage carries its own valid, so gaps in i_valid propagate unchanged and do not stall or corrupt the window.
- Back-to-back valid pixels yield back-to-back windows (throughput 1/cycle).
- i_sof on a pixel mid-frame restarts the counters at that pixel. The next valid window appears only after W−1 further full lines plus W−1 pixels.
- Reset values: o_valid=0 and o_data=0. All counters, pipeline valids and the window register are 0.
- Asserting reset mid-frame discards everything in flight. The first pixel after reset is treated as (0,0).

## Configuration
- MBW_FRAME_END_EN:
  - Defined: adds output o_eof (1 bit, reset 0). o_eof is high together with o_valid on the last window of a frame, i.e. the completing pixel at (P_IMG_HEIGHT−1, P_IMG_WIDTH−1). It has the same latency as o_valid.
  - Undefined: the port and its logic are absent.

## Structure
- The shared package holds:
  - The window-edge constant W.
  - The element bit-offset function (r*W+c)*P_DATA_WIDTH.
  - The window-count function.
- The downstream mean stage uses the same package, so the layouts cannot diverge.
- Sub-module mbw_line_buffer: one P_IMG_WIDTH-deep, read-before-write, single-clock simple dual-port memory. It is instantiated W−1 times in a generate loop.
- Counters, window shift and output register stay in the top module.

## Test plan
All scenarios use P_IMG_WIDTH=12, P_IMG_HEIGHT=10 and W=9, with pixel value = row*16+col.
- Continuous frame (i_sof on the first pixel, i_valid always high):
  - Exactly 8 windows are produced.
  - The first window has o_data(0,0)=0 and (8,8)=136, and o_valid rises 2 cycles after pixel (8,8) is sampled.
  - The last window has (0,0)=19 and (8,8)=155.
- i_valid toggled at 50% randomly: same 8 windows with identical contents in identical order. Each window arrives 2 cycles after its completing pixel.
- Two frames back to back:
  - The second frame again yields 8 windows.
  - No window is emitted during the second frame's rows 0–7.
  - Contents come solely from the second frame (use offset 0x800).
- i_sof re-asserted at (5,3) mid-frame: no window until pixel (8,8) relative to the new origin. The windows that follow match a fresh frame.
- Reset pulsed during row 9: o_valid and o_data are 0 immediately (asynchronously). After release, a full frame gives the nominal 8 windows.
- With MBW_FRAME_END_EN defined: o_eof pulses exactly once per frame, coincident with the window whose (8,8)=155. o_eof is never high otherwise.
